mpadd_seq: RTL and testbench

Multi-precision add sequencer built around the team's 16-bit Kogge-Stone adder. Accepts operand pairs as a stream of 16-bit limbs (least-significant first) on a valid/ready interface, adds each pair plus the carry held from the previous limb, and emits registered sum limbs downstream with the operation's final carry on the last limb. The adder core has no carry-in, so carry injection is done here by a second adder pass.

---
 rtl/mpadd_pkg.sv | 16 +
 rtl/ksa16.sv | 36 +++
 rtl/mpadd_seq_ksa16_ci.sv | 35 +++
 rtl/mpadd_seq.sv | 113 +++++++++++
 tb/tb_mpadd_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mpadd_pkg.sv
// Shared types and sizing helpers for the multi-precision add sequencer.
package mpadd_pkg;

  localparam int unsigned LIMB_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Limb counter width: enough to hold MAX_LIMBS-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned max_limbs);
    return int'($clog2(max_limbs)) + 1;
  endfunction

endpackage

// File: rtl/ksa16.sv
// 16-bit Kogge-Stone adder without carry-in; produces sum and carry out.
module ksa16
  import mpadd_pkg::*;
(
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  output logic [LIMB_W-1:0] o_sum,
  output logic              o_co
);

  localparam int unsigned LEVELS = 4;

  logic [LIMB_W-1:0] w_g [LEVELS+1];
  logic [LIMB_W-1:0] w_p [LEVELS+1];

  // Prefix tree: level l combines spans of distance 2^(l-1).
  always_comb begin
    w_g[0] = i_a & i_b;
    w_p[0] = i_a ^ i_b;
    for (int lvl = 1; lvl <= int'(LEVELS); lvl++) begin
      for (int i = 0; i < int'(LIMB_W); i++) begin
        if (i >= (1 << (lvl - 1))) begin
          w_g[lvl][i] = w_g[lvl-1][i] | (w_p[lvl-1][i] & w_g[lvl-1][i-(1 << (lvl - 1))]);
          w_p[lvl][i] = w_p[lvl-1][i] & w_p[lvl-1][i-(1 << (lvl - 1))];
        end else begin
          w_g[lvl][i] = w_g[lvl-1][i];
          w_p[lvl][i] = w_p[lvl-1][i];
        end
      end
    end
  end

  assign o_sum = w_p[0] ^ {w_g[LEVELS][LIMB_W-2:0], 1'b0};
  assign o_co  = w_g[LEVELS][LIMB_W-1];

endmodule

// File: rtl/mpadd_seq_ksa16_ci.sv
// 16-bit add with carry-in built from two carry-in-less ksa16 passes.
module ksa16_ci
  import mpadd_pkg::*;
(
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  input  logic              i_ci,
  output logic [LIMB_W-1:0] o_sum,
  output logic              o_co
);

  logic [LIMB_W-1:0] w_s1;
  logic [LIMB_W-1:0] w_s2;
  logic              w_c1;
  logic              w_c2;

  ksa16 u_pass1 (
    .i_a   (i_a),
    .i_b   (i_b),
    .o_sum (w_s1),
    .o_co  (w_c1)
  );

  // Second pass injects the carry; c1 and c2 can never both be set.
  ksa16 u_pass2 (
    .i_a   (w_s1),
    .i_b   (LIMB_W'(i_ci)),
    .o_sum (w_s2),
    .o_co  (w_c2)
  );

  assign o_sum = w_s2;
  assign o_co  = w_c1 | w_c2;

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add sequencer: streams limb pairs LS-first, propagates carry
// between limbs and emits registered sum limbs with the final carry on the last.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int unsigned MAX_LIMBS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_err
);

  localparam int unsigned CNT_W = cnt_width(MAX_LIMBS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_carry;
  logic              w_carry_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_out_valid;
  logic [LIMB_W-1:0] r_out_sum;
  logic              r_out_last;
  logic              r_out_carry;
  logic              r_out_err;

  logic              w_accept;
  logic              w_eff_last;
  logic              w_carry_in;
  logic [LIMB_W-1:0] w_sum;
  logic              w_limb_carry;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_eff_last = in_last || (r_cnt == CNT_W'(MAX_LIMBS - 1));
  // A fresh operation always starts with carry 0.
  assign w_carry_in = (r_state == RUN) ? r_carry : 1'b0;

  ksa16_ci u_add (
    .i_a   (in_a),
    .i_b   (in_b),
    .i_ci  (w_carry_in),
    .o_sum (w_sum),
    .o_co  (w_limb_carry)
  );

  // Next-state and per-operation carry/count bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      if (w_eff_last) begin
        w_state_nxt = IDLE;
        w_carry_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = RUN;
        w_carry_nxt = w_limb_carry;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One-entry output register; reloads on accept, drains on emit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_carry <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_last  <= w_eff_last;
      r_out_carry <= w_eff_last && w_limb_carry;
      r_out_err   <= w_eff_last && !in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_carry = r_out_carry;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mpadd_seq.sv
// Scoreboard bench for mpadd_seq: directed limb streams with hand-computed sums.
module tb_mpadd_seq;

  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        carry;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_carry;
  logic        out_err;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          bp_en = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          pk = 0;

  mpadd_seq #(.MAX_LIMBS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Downstream ready: constant 1, or the 1,0,0,1 pattern while bp_en is set.
  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? pat[pk] : 1'b1;
    pk = (pk + 1) % 4;
  end

  // Monitor: every presented limb must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t got;
    if (rst_n && out_valid) begin
      got = '{sum: out_sum, last: out_last, carry: out_carry, err: out_err};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out got sum=%h last=%b carry=%b err=%b, none expected",
                 got.sum, got.last, got.carry, got.err);
      end else begin
        if (got !== q[0]) begin
          n_bad++;
          $display("FAIL out_limb got sum=%h last=%b carry=%b err=%b, want sum=%h last=%b carry=%b err=%b",
                   got.sum, got.last, got.carry, got.err, q[0].sum, q[0].last, q[0].carry, q[0].err);
        end
        if (out_ready) begin
          void'(q.pop_front());
        end else begin
          n_cmp++;
          if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_in_ready got %b want 0", in_ready);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic [15:0] es, input logic el, input logic ec, input logic ee,
                      input bit push);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (push) q.push_back('{sum: es, last: el, carry: ec, err: ee});
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout a=%h b=%h never accepted", a, b);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_sum_nz", |out_sum, 1'b0);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_out_carry", out_carry, 1'b0);
    check1("rst_out_err", out_err, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-limb operation.
    send(16'h1234, 16'h0001, 1'b1, 16'h1235, 1'b1, 1'b0, 1'b0, 1'b1);
    // Carry out of first pass feeds the second limb.
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    // Carry generated by the injection pass, then cleared for the next op.
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: out_ready cycles 1,0,0,1.
    bp_en = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0001, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Truncation at MAX_LIMBS=4; the fifth limb is its own operation.
    for (int i = 0; i < 3; i++)
      send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);
    send(16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Reset mid-operation discards the pending limb and the held carry.
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
